// File: rtl/int_cont_bank_if.sv
// ---------------------------------------------------------------------------
// int_cont_bank_if -- bus bundle for the interrupt controller bank.
//
// Carries the command, request and acknowledge inputs of int_cont_bank and
// its mask, summary and ID outputs. The clock and reset are not part of the
// bundle; they connect to the controller as plain ports.
//
//   V1                   timing phase strobe (state moves only when high)
//   Z3/ICRV/INFOV/PBAV   command qualifiers, all four high = command valid
//   ADDR  [AW-1:0]       channel address of a command
//   A3                   command sense: 0 = mask channel, 1 = enable channel
//   INT_REQ [NCH-1:0]    raw request lines, level sampled
//   INT_ACK              acknowledge of the interrupt currently presented
//   ICRN  [NCH-1:0]      active-low mask state per channel
//   INT                  some channel is pending and enabled
//   INT_ID [AW-1:0]      lowest-index pending and enabled channel
//
// master: the side that drives commands/requests (CPU side, bench).
// slave : the controller itself.
// ---------------------------------------------------------------------------
interface int_cont_bank_if #(
  parameter int NCH = 8,
  parameter int AW  = 4
);
  logic           V1;
  logic           Z3;
  logic           ICRV;
  logic           INFOV;
  logic           PBAV;
  logic [AW-1:0]  ADDR;
  logic           A3;
  logic [NCH-1:0] INT_REQ;
  logic           INT_ACK;
  logic [NCH-1:0] ICRN;
  logic           INT;
  logic [AW-1:0]  INT_ID;

  modport master (
    output V1, Z3, ICRV, INFOV, PBAV, ADDR, A3, INT_REQ, INT_ACK,
    input  ICRN, INT, INT_ID
  );

  modport slave (
    input  V1, Z3, ICRV, INFOV, PBAV, ADDR, A3, INT_REQ, INT_ACK,
    output ICRN, INT, INT_ID
  );
endinterface

// File: rtl/int_cont_bank.sv
// ---------------------------------------------------------------------------
// int_cont_bank -- bank of NCH maskable, sticky interrupt channels with a
// fixed-priority presenter (lowest index wins) and an acknowledge that
// retires the presented channel.
//
// Ports:
//   SIM_CLK   in   system clock, rising edge
//   SIM_RST   in   asynchronous active-high reset
//   bus       int_cont_bank_if.slave (see interface header for signals)
//
// Parameters:
//   NCH  number of channels, 1..15
//   AW   width of ADDR / INT_ID; NCH must not exceed 2**AW-1
//
// Build option:
//   INT_CONT_BROADCAST_EN  when defined, a command to address 2**AW-1
//                          writes the same mask value to every channel;
//                          when undefined, that address is simply out of
//                          range and the command is dropped.
//
// Every register update is gated by V1; SIM_CLK edges with V1 low leave the
// state untouched. Outputs are decoded combinationally from the registers,
// so a captured change is visible right after its V1 edge.
// ---------------------------------------------------------------------------
module int_cont_bank #(
  parameter int NCH = 8,
  parameter int AW  = 4
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  int_cont_bank_if.slave  bus
);

  logic [NCH-1:0] icr;       // 1 = channel masked
  logic [NCH-1:0] pend;      // sticky pending flags
  logic [NCH-1:0] icr_nxt;
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] ena;
  logic [AW-1:0]  int_id_c;
  logic           int_c;
  logic           cmd;

`ifdef INT_CONT_BROADCAST_EN
  localparam logic [AW-1:0] BCAST_ADDR = '1;
`endif

  assign cmd = bus.Z3 & bus.ICRV & bus.INFOV & bus.PBAV;

  // Presenter: mask out inhibited channels, pick the lowest set index.
  assign ena   = pend & ~icr;
  assign int_c = |ena;

  always_comb begin
    int_id_c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ena[i]) int_id_c = AW'(i);
    end
  end

  // Mask update. The loop compare only hits i < NCH, so out-of-range
  // addresses fall through without touching any bit.
  always_comb begin
    icr_nxt = icr;
    if (cmd) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ADDR == AW'(i)) icr_nxt[i] = ~bus.A3;
      end
`ifdef INT_CONT_BROADCAST_EN
      if (bus.ADDR == BCAST_ADDR) icr_nxt = {NCH{~bus.A3}};
`endif
    end
  end

  // Pending update. The ack clears the channel presented before this edge;
  // new requests are OR-ed in afterwards so a simultaneous request on the
  // acknowledged channel keeps it pending.
  always_comb begin
    pend_nxt = pend;
    if (bus.INT_ACK && int_c) begin
      for (int i = 0; i < NCH; i++) begin
        if (int_id_c == AW'(i)) pend_nxt[i] = 1'b0;
      end
    end
    pend_nxt = pend_nxt | bus.INT_REQ;
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      icr  <= '1;
      pend <= '0;
    end else if (bus.V1) begin
      icr  <= icr_nxt;
      pend <= pend_nxt;
    end
  end

  assign bus.ICRN   = ~icr;
  assign bus.INT    = int_c;
  assign bus.INT_ID = int_id_c;

endmodule

// File: doc/int_cont_bank.md
INT_CONT_BANK -- requirements
Module: int_cont_bank

Interface
REQ-001 Parameter NCH, default 8: number of interrupt channels, 1..15.
REQ-002 Parameter AW, default 4: channel address and ID width; NCH SHALL NOT exceed 2^AW-1.
REQ-003 SIM_CLK  in  1: single system clock, rising-edge active.
REQ-004 SIM_RST  in  1: asynchronous, active-high reset.
REQ-005 V1  in  1: timing phase strobe; all state updates SHALL occur only on SIM_CLK edges where V1=1.
REQ-006 Z3, ICRV, INFOV, PBAV  in  1 each: command qualifiers; command valid (CMD) = all four high.
REQ-007 ADDR  in  AW: channel address of the command.
REQ-008 A3  in  1: command sense; 0 = set mask (inhibit), 1 = clear mask (enable).
REQ-009 INT_REQ  in  NCH: raw interrupt request lines, level-sampled.
REQ-010 INT_ACK  in  1: acknowledge of the currently presented interrupt.
REQ-011 ICRN  out  NCH: active-low mask state per channel (ICRN[i]=0 means channel i inhibited).
REQ-012 INT  out  1: interrupt-pending-and-enabled summary.
REQ-013 INT_ID  out  AW: index of the highest-priority presented channel.

Function
REQ-014 Internal registers: ICR[NCH-1:0] (1 = masked), PEND[NCH-1:0]; ICRN SHALL equal ~ICR.
REQ-015 On a V1 edge with CMD=1 and ADDR<NCH: ICR[ADDR] <= ~A3; other bits SHALL hold.
REQ-016 CMD with ADDR>=NCH (other than broadcast, REQ-030) SHALL be ignored.
REQ-017 On every V1 edge, PEND[i] <= PEND[i] | INT_REQ[i], regardless of mask; pending is sticky.
REQ-018 ENA = PEND & ~ICR; INT SHALL be |ENA, combinational from registers.
REQ-019 INT_ID SHALL be the lowest index i with ENA[i]=1 (lowest index = highest priority); 0 when INT=0.
REQ-020 On a V1 edge with INT_ACK=1 and INT=1: PEND[INT_ID] cleared, using INT_ID valid before the edge.
REQ-021 INT_ACK with INT=0, or INT_ACK/CMD with V1=0, SHALL have no effect.
REQ-022 Ack and INT_REQ[INT_ID]=1 on the same edge: request wins, PEND bit stays 1.
REQ-023 Command and ack on the same edge SHALL both apply independently; mask change does not cancel the ack.
REQ-024 Latency: ICRN, INT, INT_ID SHALL reflect a command/request/ack immediately after the capturing V1 edge (one SIM_CLK), no further pipeline.
REQ-025 Masking a pending channel SHALL hide it from INT/INT_ID without clearing PEND; unmasking re-presents it.

Reset
REQ-026 SIM_RST=1 SHALL immediately (asynchronously) set ICR all ones (ICRN=0), PEND=0, INT=0, INT_ID=0.
REQ-027 Reset asserted mid-command or mid-ack SHALL discard that operation; state after release is the reset state.
REQ-028 First update after reset deassertion SHALL occur at the first SIM_CLK edge with V1=1.

Configuration
REQ-029 Macro INT_CONT_BROADCAST_EN selects broadcast commands.
REQ-030 Defined: CMD with ADDR = 2^AW-1 SHALL set ICR to all ~A3 (every channel at once).
REQ-031 Undefined: ADDR = 2^AW-1 is an ordinary out-of-range address and SHALL be ignored per REQ-016.

Verification (NCH=8, AW=4)
REQ-032 Reset, then CMD ADDR=3 A3=1 with V1=1 -> ICRN=8'h08; repeat with V1=0 -> no change.
REQ-033 All unmasked, INT_REQ=8'h24 one V1 edge -> INT=1, INT_ID=2; ack -> INT_ID=5; ack -> INT=0.
REQ-034 PEND[2] set, mask ch2 (ADDR=2 A3=0) -> INT=0, PEND held; unmask -> INT=1, INT_ID=2.
REQ-035 Ack ch2 while INT_REQ[2]=1 same edge -> INT stays 1, INT_ID=2; ADDR=9 command -> ICRN unchanged.
REQ-036 With INT_CONT_BROADCAST_EN: ADDR=15 A3=1 -> ICRN=8'hFF; A3=0 -> 8'h00; without macro -> unchanged; SIM_RST pulse mid-sequence -> ICRN=0, INT=0.
